// File: rtl/depth_buffer_writer_pkg.sv
// raster_pkg: shared types and constants for the rasterizer framebuffer backend.
// Contents:
//   fb_state_t    - writer FSM states (RUN, DRAIN, CLEAR, DONE)
//   fb_size()     - framebuffer size in pixels from screen dimensions
//   MAX_DEPTH_ALL - all-ones depth; users slice it to their depth width
package raster_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_t;

  localparam int MAX_DEPTH_BITS = 32;

  // The farthest depth is all ones at any width up to MAX_DEPTH_BITS.
  localparam logic [MAX_DEPTH_BITS-1:0] MAX_DEPTH_ALL = 32'hFFFF_FFFF;

  function automatic int fb_size(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/depth_buffer_writer_if.sv
// depth_buffer_writer_if: pixel stream, clear control and depth/color BRAM ports
// of the depth buffer writer.
// Modports:
//   slave  - the writer: consumes pixels and clear requests, drives the BRAM ports
//   master - the producer/memory side: drives pixels, clear and BRAM read data
interface depth_buffer_writer_if #(
  parameter int DATAWIDTH  = 12,
  parameter int COLORWIDTH = 4,
  parameter int ADDRWIDTH  = 16
);

  logic [ADDRWIDTH-1:0]  i_addr;
  logic                  i_we;
  logic [DATAWIDTH-1:0]  i_depth;
  logic [COLORWIDTH-1:0] i_color;
  logic                  o_ready;
  logic                  i_clear;
  logic                  o_clear_busy;
  logic                  o_clear_done;
  logic [ADDRWIDTH-1:0]  o_depth_raddr;
  logic [DATAWIDTH-1:0]  i_depth_rdata;
  logic [ADDRWIDTH-1:0]  o_depth_waddr;
  logic [DATAWIDTH-1:0]  o_depth_wdata;
  logic                  o_depth_we;
  logic [ADDRWIDTH-1:0]  o_color_waddr;
  logic [COLORWIDTH-1:0] o_color_wdata;
  logic                  o_color_we;

  modport slave (
    input  i_addr, i_we, i_depth, i_color, i_clear, i_depth_rdata,
    output o_ready, o_clear_busy, o_clear_done, o_depth_raddr,
           o_depth_waddr, o_depth_wdata, o_depth_we,
           o_color_waddr, o_color_wdata, o_color_we
  );

  modport master (
    output i_addr, i_we, i_depth, i_color, i_clear, i_depth_rdata,
    input  o_ready, o_clear_busy, o_clear_done, o_depth_raddr,
           o_depth_waddr, o_depth_wdata, o_depth_we,
           o_color_waddr, o_color_wdata, o_color_we
  );

endinterface

// File: rtl/depth_buffer_writer_fwd_mux.sv
// depth_fwd_mux: selects the "old" depth for the S1 compare.
// The BRAM is read-first, so the two most recent writes (W0 on the output
// registers, W1 one cycle older) are not yet visible in the read data.
// Ports:
//   s1_addr              - address of the pixel under test
//   w0_valid/addr/depth  - write currently on the output registers (highest priority)
//   w1_valid/addr/depth  - write from the previous cycle
//   rd_depth             - BRAM read data
//   old_depth            - selected stored depth
module depth_fwd_mux
  import raster_pkg::*;
#(
  parameter int DATAWIDTH = 12,
  parameter int ADDRWIDTH = 16
) (
  input  logic [ADDRWIDTH-1:0] s1_addr,
  input  logic                 w0_valid,
  input  logic [ADDRWIDTH-1:0] w0_addr,
  input  logic [DATAWIDTH-1:0] w0_depth,
  input  logic                 w1_valid,
  input  logic [ADDRWIDTH-1:0] w1_addr,
  input  logic [DATAWIDTH-1:0] w1_depth,
  input  logic [DATAWIDTH-1:0] rd_depth,
  output logic [DATAWIDTH-1:0] old_depth
);

  // Newest matching write wins; fall back to the BRAM otherwise.
  always_comb begin
    old_depth = rd_depth;
    if (w0_valid && (w0_addr == s1_addr)) begin
      old_depth = w0_depth;
    end else if (w1_valid && (w1_addr == s1_addr)) begin
      old_depth = w1_depth;
    end else begin
      old_depth = rd_depth;
    end
  end

endmodule

// File: rtl/depth_buffer_writer.sv
// depth_buffer_writer: consumer end of the framebuffer write stream.
// Accepts one pixel per cycle, performs a strict less-than depth test against
// the stored (or forwarded) depth and commits passing pixels to the depth and
// color buffers two cycles after acceptance. An i_clear pulse drains the
// pipeline and sweeps every location with max depth and CLEAR_COLOR.
// Ports:
//   clk, rstn - clock and synchronous active-low reset
//   bus       - pixel stream, clear control and BRAM ports (slave modport)
module depth_buffer_writer
  import raster_pkg::*;
#(
  parameter int DATAWIDTH     = 12,
  parameter int COLORWIDTH    = 4,
  parameter int ADDRWIDTH     = 16,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 200,
  parameter int CLEAR_COLOR   = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  depth_buffer_writer_if.slave bus
);

  localparam int                    FB_SIZE    = fb_size(SCREEN_WIDTH, SCREEN_HEIGHT);
  localparam logic [ADDRWIDTH-1:0]  SWEEP_LAST = ADDRWIDTH'(FB_SIZE - 1);
  localparam logic [DATAWIDTH-1:0]  MAX_DEPTH  = MAX_DEPTH_ALL[DATAWIDTH-1:0];
  localparam logic [COLORWIDTH-1:0] CLR_COLOR  = COLORWIDTH'(CLEAR_COLOR);

  fb_state_t state_q, state_d;
  logic      drain_first_q, drain_first_d;
  logic [ADDRWIDTH-1:0] sweep_q, sweep_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDRWIDTH-1:0]  s1_addr_q, s1_addr_d;
  logic [DATAWIDTH-1:0]  s1_depth_q, s1_depth_d;
  logic [COLORWIDTH-1:0] s1_color_q, s1_color_d;

  // Output write registers; these also act as W0 for forwarding.
  logic                  wr_we_q, wr_we_d;
  logic [ADDRWIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]  wr_depth_q, wr_depth_d;
  logic [COLORWIDTH-1:0] wr_color_q, wr_color_d;

  logic                 w1_valid_q, w1_valid_d;
  logic [ADDRWIDTH-1:0] w1_addr_q, w1_addr_d;
  logic [DATAWIDTH-1:0] w1_depth_q, w1_depth_d;

  logic                 ready_s, busy_s, done_s, accept_s, pass_s;
  logic [DATAWIDTH-1:0] old_depth_s;

  depth_fwd_mux #(
    .DATAWIDTH (DATAWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_fwd (
    .s1_addr   (s1_addr_q),
    .w0_valid  (wr_we_q),
    .w0_addr   (wr_addr_q),
    .w0_depth  (wr_depth_q),
    .w1_valid  (w1_valid_q),
    .w1_addr   (w1_addr_q),
    .w1_depth  (w1_depth_q),
    .rd_depth  (bus.i_depth_rdata),
    .old_depth (old_depth_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.i_clear) state_d = ST_DRAIN;
        else             state_d = ST_RUN;
      end
      // The first DRAIN cycle still has S1 loaded from the clear cycle; by the
      // second, S1 is empty and nothing new is headed for the write registers.
      ST_DRAIN: begin
        if (!drain_first_q && !s1_valid_q && !wr_we_d) state_d = ST_CLEAR;
        else                                            state_d = ST_DRAIN;
      end
      ST_CLEAR: begin
        if (sweep_q == SWEEP_LAST) state_d = ST_DONE;
        else                       state_d = ST_CLEAR;
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM output decode.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      ST_RUN:   ready_s = 1'b1;
      ST_DRAIN: busy_s  = 1'b1;
      ST_CLEAR: busy_s  = 1'b1;
      ST_DONE:  done_s  = 1'b1;
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  assign pass_s = (s1_depth_q < old_depth_s);

  // Datapath next values: S1 capture, depth test / clear write, W1 history, sweep.
  always_comb begin
    accept_s      = bus.i_we && ready_s;
    drain_first_d = (state_q == ST_RUN) && bus.i_clear;

    s1_valid_d = accept_s;
    if (accept_s) begin
      s1_addr_d  = bus.i_addr;
      s1_depth_d = bus.i_depth;
      s1_color_d = bus.i_color;
    end else begin
      s1_addr_d  = s1_addr_q;
      s1_depth_d = s1_depth_q;
      s1_color_d = s1_color_q;
    end

    if (state_q == ST_CLEAR) begin
      wr_we_d    = 1'b1;
      wr_addr_d  = sweep_q;
      wr_depth_d = MAX_DEPTH;
      wr_color_d = CLR_COLOR;
    end else if (s1_valid_q && pass_s) begin
      wr_we_d    = 1'b1;
      wr_addr_d  = s1_addr_q;
      wr_depth_d = s1_depth_q;
      wr_color_d = s1_color_q;
    end else begin
      wr_we_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_depth_d = wr_depth_q;
      wr_color_d = wr_color_q;
    end

    w1_valid_d = wr_we_q;
    w1_addr_d  = wr_addr_q;
    w1_depth_d = wr_depth_q;

    // Terminal compare against FB_SIZE-1, so the counter never wraps.
    if (state_q == ST_CLEAR) begin
      if (sweep_q == SWEEP_LAST) sweep_d = {ADDRWIDTH{1'b0}};
      else                       sweep_d = sweep_q + ADDRWIDTH'(1);
    end else begin
      sweep_d = {ADDRWIDTH{1'b0}};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drain_first_q <= 1'b0;
      sweep_q       <= {ADDRWIDTH{1'b0}};
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= {ADDRWIDTH{1'b0}};
      s1_depth_q    <= {DATAWIDTH{1'b0}};
      s1_color_q    <= {COLORWIDTH{1'b0}};
      wr_we_q       <= 1'b0;
      wr_addr_q     <= {ADDRWIDTH{1'b0}};
      wr_depth_q    <= {DATAWIDTH{1'b0}};
      wr_color_q    <= {COLORWIDTH{1'b0}};
      w1_valid_q    <= 1'b0;
      w1_addr_q     <= {ADDRWIDTH{1'b0}};
      w1_depth_q    <= {DATAWIDTH{1'b0}};
    end else begin
      drain_first_q <= drain_first_d;
      sweep_q       <= sweep_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_depth_q    <= s1_depth_d;
      s1_color_q    <= s1_color_d;
      wr_we_q       <= wr_we_d;
      wr_addr_q     <= wr_addr_d;
      wr_depth_q    <= wr_depth_d;
      wr_color_q    <= wr_color_d;
      w1_valid_q    <= w1_valid_d;
      w1_addr_q     <= w1_addr_d;
      w1_depth_q    <= w1_depth_d;
    end
  end

  assign bus.o_ready       = ready_s;
  assign bus.o_clear_busy  = busy_s;
  assign bus.o_clear_done  = done_s;
  assign bus.o_depth_raddr = bus.i_addr;
  assign bus.o_depth_waddr = wr_addr_q;
  assign bus.o_depth_wdata = wr_depth_q;
  assign bus.o_depth_we    = wr_we_q;
  assign bus.o_color_waddr = wr_addr_q;
  assign bus.o_color_wdata = wr_color_q;
  assign bus.o_color_we    = wr_we_q;

endmodule

// File: tb/tb_depth_buffer_writer.sv
// tb_depth_buffer_writer: directed bench for depth_buffer_writer with a small
// framebuffer (4x2). A read-first BRAM model backs the DUT; an ideal in-order
// z-buffer model predicts each pixel's write, queued and compared two cycles later.
module tb_depth_buffer_writer;

  localparam int DW = 12;
  localparam int CW = 4;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int CC = 2;
  localparam int FB = SW * SH;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] depth;
    logic [CW-1:0] color;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  depth_buffer_writer_if #(.DATAWIDTH(DW), .COLORWIDTH(CW), .ADDRWIDTH(AW)) bus ();

  depth_buffer_writer #(
    .DATAWIDTH     (DW),
    .COLORWIDTH    (CW),
    .ADDRWIDTH     (AW),
    .SCREEN_WIDTH  (SW),
    .SCREEN_HEIGHT (SH),
    .CLEAR_COLOR   (CC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DW-1:0] dmem [0:255];
  logic [CW-1:0] cmem [0:255];
  logic [DW-1:0] ref_d [0:255];
  exp_t          sbq [$];

  // Read-first BRAM model; preloaded to far depth while reset is held.
  always @(posedge clk) begin
    bus.i_depth_rdata <= dmem[bus.o_depth_raddr[7:0]];
    if (!rstn) begin
      for (int i = 0; i < 256; i++) begin
        dmem[i] <= 12'hFFF;
        cmem[i] <= 4'h0;
      end
    end else begin
      if (bus.o_depth_we) dmem[bus.o_depth_waddr[7:0]] <= bus.o_depth_wdata;
      if (bus.o_color_we) cmem[bus.o_color_waddr[7:0]] <= bus.o_color_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pixel input, predict its outcome, and check the
  // prediction queued two cycles earlier against the write ports.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [CW-1:0] c);
    exp_t e;
    bus.i_we    = v;
    bus.i_addr  = a;
    bus.i_depth = d;
    bus.i_color = c;
    e.we = 1'b0; e.addr = a; e.depth = d; e.color = c;
    if (v && (d < ref_d[a[7:0]])) begin
      e.we = 1'b1;
      ref_d[a[7:0]] = d;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.i_we = 1'b0;
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      chk("depth_we", bus.o_depth_we, e.we);
      chk("color_we", bus.o_color_we, e.we);
      if (e.we) begin
        chk("depth_waddr", bus.o_depth_waddr, e.addr);
        chk("depth_wdata", bus.o_depth_wdata, e.depth);
        chk("color_waddr", bus.o_color_waddr, e.addr);
        chk("color_wdata", bus.o_color_wdata, e.color);
      end
    end
  endtask

  initial begin
    logic [AW-1:0] wa [$];
    logic [DW-1:0] wd [$];
    logic [CW-1:0] wc [$];
    int low_cnt;
    int done_cnt;
    logic found;

    for (int i = 0; i < 256; i++) ref_d[i] = 12'hFFF;
    bus.i_addr  = '0;
    bus.i_we    = 1'b0;
    bus.i_depth = '0;
    bus.i_color = '0;
    bus.i_clear = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_depth_we", bus.o_depth_we, 1'b0);
    chk("rst_color_we", bus.o_color_we, 1'b0);
    chk("rst_ready", bus.o_ready, 1'b1);
    chk("rst_busy", bus.o_clear_busy, 1'b0);
    chk("rst_done", bus.o_clear_done, 1'b0);
    rstn = 1'b1;

    // Single pixel, forwarding from W0, W0-over-W1 priority, equal-depth tie
    step(1'b1, 16'd10, 12'h100, 4'd3);
    step(1'b1, 16'd5,  12'h200, 4'd1);
    step(1'b1, 16'd5,  12'h300, 4'd2);
    step(1'b1, 16'd7,  12'h300, 4'd4);
    step(1'b1, 16'd7,  12'h280, 4'd5);
    step(1'b1, 16'd7,  12'h290, 4'd6);
    step(1'b1, 16'd9,  12'h050, 4'd7);
    step(1'b0, 16'd0,  12'h000, 4'd0);
    step(1'b1, 16'd9,  12'h050, 4'd8);
    step(1'b1, 16'd10, 12'h0FF, 4'd9);

    // Random burst over a small address window to stress forwarding
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(1, 0) == 1, AW'($urandom_range(23, 16)),
           DW'($urandom_range(4095, 0)), CW'($urandom_range(15, 0)));
    end
    step(1'b0, 16'd0, 12'h000, 4'd0);
    step(1'b0, 16'd0, 12'h000, 4'd0);
    sbq.delete();

    // Clear with a pixel accepted in the same cycle; pixels offered while busy
    bus.i_clear = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_addr  = 16'd12;
    bus.i_depth = 12'h010;
    bus.i_color = 4'd9;
    ref_d[12]   = 12'h010;
    @(posedge clk); #1;
    bus.i_clear = 1'b0;
    bus.i_we    = 1'b0;
    low_cnt  = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!bus.o_ready) low_cnt++;
      if (bus.o_clear_done) done_cnt++;
      if (bus.o_depth_we) begin
        wa.push_back(bus.o_depth_waddr);
        wd.push_back(bus.o_depth_wdata);
        wc.push_back(bus.o_color_wdata);
      end
      bus.i_we    = !bus.o_ready;
      bus.i_addr  = 16'd13;
      bus.i_depth = 12'h001;
      @(posedge clk); #1;
    end
    bus.i_we = 1'b0;
    chk("clear_ready_low_cycles", low_cnt, 11);
    chk("clear_done_pulses", done_cnt, 1);
    chk("clear_write_count", wa.size(), FB + 1);
    if (wa.size() == FB + 1) begin
      chk("same_cycle_pixel_addr", wa[0], 16'd12);
      chk("same_cycle_pixel_depth", wd[0], 12'h010);
      for (int i = 0; i < FB; i++) begin
        chk("clear_addr", wa[i+1], i);
        chk("clear_depth", wd[i+1], 12'hFFF);
        chk("clear_color", wc[i+1], CC);
      end
    end
    for (int i = 0; i < FB; i++) begin
      chk("mem_depth_cleared", dmem[i], 12'hFFF);
      chk("mem_color_cleared", cmem[i], CC);
      ref_d[i] = 12'hFFF;
    end
    chk("mem_pixel12", dmem[12], 12'h010);
    chk("ready_after_clear", bus.o_ready, 1'b1);

    // Normal operation resumes after the sweep
    step(1'b1, 16'd2, 12'hFFE, 4'd1);
    step(1'b1, 16'd3, 12'hFFF, 4'd1);
    step(1'b0, 16'd0, 12'h000, 4'd0);
    step(1'b0, 16'd0, 12'h000, 4'd0);
    sbq.delete();

    // Reset in the middle of a sweep
    bus.i_clear = 1'b1;
    @(posedge clk); #1;
    bus.i_clear = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (!found) begin
        if (bus.o_depth_we && (bus.o_depth_waddr == 16'd3)) begin
          found = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    chk("midclear_reached_addr3", found, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midclear_rst_depth_we", bus.o_depth_we, 1'b0);
    chk("midclear_rst_color_we", bus.o_color_we, 1'b0);
    chk("midclear_rst_ready", bus.o_ready, 1'b1);
    chk("midclear_rst_busy", bus.o_clear_busy, 1'b0);
    rstn = 1'b1;
    low_cnt  = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!bus.o_ready) low_cnt++;
      if (bus.o_clear_done) done_cnt++;
      @(posedge clk); #1;
    end
    chk("midclear_no_done", done_cnt, 0);
    chk("midclear_ready_stays", low_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
